stack_ptr_decoder: RTL and testbench

Parametrised successor to the team's fixed 2-to-4 enable-gated decoder. It combines a push-down stack pointer with an N-to-2^N one-hot row decoder, so it can drive the word-select lines of the stack RAM directly. It registers the row select and the write/read strobe, and tracks entry count, full/empty and sticky overflow/underflow flags. It sits between the stack front-end (push/pop requests) and the word-addressed RAM array.

---
 rtl/stack_ptr_decoder_pkg.sv | 20 ++
 rtl/stack_ptr_decoder_dec_n_to_onehot.sv | 18 +
 rtl/stack_ptr_decoder.sv | 126 ++++++++++++
 tb/tb_stack_ptr_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ptr_decoder_pkg.sv
// Shared definitions for the stack pointer / row decoder slice.
package stack_ptr_decoder_pkg;

    // Operation chosen for the current cycle once push/pop have been qualified
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } stack_op_e;

    // Largest row-address width the stack is intended for
    localparam int ADDR_W_MAX = 6;

    // Number of stack entries addressed by an addr_w-bit row index
    function automatic int depth_f(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/stack_ptr_decoder_dec_n_to_onehot.sv
// Enable-gated N-to-2^N one-hot decoder, combinational.
module dec_n_to_onehot #(
    parameter int N = 2
) (
    input  logic [N-1:0]        data_i,
    input  logic                e_i,
    output logic [(1<<N)-1:0]   data_o
);

    // One output line per row; a line is high only when enabled and addressed
    genvar gi;
    generate
        for (gi = 0; gi < (1 << N); gi++) begin : g_row
            assign data_o[gi] = e_i & (data_i == N'(gi));
        end
    endgenerate

endmodule

// File: rtl/stack_ptr_decoder.sv
// Push-down stack pointer driving a one-hot RAM row select.
// Accepted push/pop/replace operations produce a one-cycle registered strobe
// one cycle later; rejected operations set sticky overflow/underflow flags.
module stack_ptr_decoder
    import stack_ptr_decoder_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      e_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      clr_i,
    output logic [(1<<ADDR_W)-1:0]    sel_o,
    output logic                      we_o,
    output logic                      valid_o,
    output logic [ADDR_W-1:0]         top_o,
    output logic [ADDR_W:0]           count_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      ovf_o,
    output logic                      udf_o
);

    localparam int DEPTH = depth_f(ADDR_W);
    // Count and row arithmetic carry one extra bit so DEPTH is representable
    localparam int CW    = ADDR_W + 1;

    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] row_q;
    logic              we_q;
    logic              valid_q;
    logic              ovf_q;
    logic              udf_q;

    stack_op_e         op;
    logic              ovf_set;
    logic              udf_set;
    logic [CW-1:0]     row_wide;
    logic              row_ok;
    logic              accept;
    logic              empty;
    logic              full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Qualify the request against the current occupancy
    always_comb begin
        op      = OP_IDLE;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (e_i) begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (full) ovf_set = 1'b1;
                    else      op      = OP_PUSH;
                end
                2'b01: begin
                    if (empty) udf_set = 1'b1;
                    else       op      = OP_POP;
                end
                // Push+pop on an empty stack degenerates to a plain push
                2'b11:   op = empty ? OP_PUSH : OP_REPL;
                default: op = OP_IDLE;
            endcase
        end
    end

    // Row index in full width, range-checked before it is truncated
    always_comb begin
        row_wide = (op == OP_PUSH) ? count_q : (count_q - CW'(1));
        row_ok   = (row_wide < CW'(DEPTH));
        accept   = (op != OP_IDLE) && row_ok;
        count_d  = count_q;
        if (accept) begin
            case (op)
                OP_PUSH: count_d = count_q + CW'(1);
                OP_POP:  count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy, strobe and sticky flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= accept;
            we_q    <= accept && (op != OP_POP);
            row_q   <= accept ? row_wide[ADDR_W-1:0] : '0;
            // A rejection in the same cycle as a clear keeps the flag set
            ovf_q   <= ovf_set | (ovf_q & ~clr_i);
            udf_q   <= udf_set | (udf_q & ~clr_i);
        end
    end

    // Row select is only driven while the registered strobe is valid
    dec_n_to_onehot #(
        .N (ADDR_W)
    ) u_dec (
        .data_i (row_q),
        .e_i    (valid_q),
        .data_o (sel_o)
    );

    assign we_o    = we_q;
    assign valid_o = valid_q;
    assign count_o = count_q;
    assign empty_o = empty;
    assign full_o  = full;
    // Top entry is count-1; when full that is the all-ones row
    assign top_o   = full  ? '1 :
                     empty ? '0 : (count_q[ADDR_W-1:0] - ADDR_W'(1));
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

endmodule

// File: tb/tb_stack_ptr_decoder.sv
// Directed bench for stack_ptr_decoder at ADDR_W=2 and ADDR_W=3.
module tb_stack_ptr_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // ADDR_W = 2 instance
    logic       e_a, push_a, pop_a, clr_a;
    logic [3:0] sel_a;
    logic       we_a, valid_a, empty_a, full_a, ovf_a, udf_a;
    logic [1:0] top_a;
    logic [2:0] count_a;

    // ADDR_W = 3 instance
    logic       e_b, push_b, pop_b, clr_b;
    logic [7:0] sel_b;
    logic       we_b, valid_b, empty_b, full_b, ovf_b, udf_b;
    logic [2:0] top_b;
    logic [3:0] count_b;

    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b0;

    stack_ptr_decoder #(.ADDR_W(2)) dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .e_i     (e_a),
        .push_i  (push_a),
        .pop_i   (pop_a),
        .clr_i   (clr_a),
        .sel_o   (sel_a),
        .we_o    (we_a),
        .valid_o (valid_a),
        .top_o   (top_a),
        .count_o (count_a),
        .empty_o (empty_a),
        .full_o  (full_a),
        .ovf_o   (ovf_a),
        .udf_o   (udf_a)
    );

    stack_ptr_decoder #(.ADDR_W(3)) dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .e_i     (e_b),
        .push_i  (push_b),
        .pop_i   (pop_b),
        .clr_i   (clr_b),
        .sel_o   (sel_b),
        .we_o    (we_b),
        .valid_o (valid_b),
        .top_o   (top_b),
        .count_o (count_b),
        .empty_o (empty_b),
        .full_o  (full_b),
        .ovf_o   (ovf_b),
        .udf_o   (udf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input logic e, input logic push, input logic pop, input logic clr);
        e_a = e; push_a = push; pop_a = pop; clr_a = clr;
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t a: sel=%b we=%b v=%b cnt=%0d ovf=%b udf=%b | b: sel=%b cnt=%0d ovf=%b",
                 $time, sel_a, we_a, valid_a, count_a, ovf_a, udf_a, sel_b, count_b, ovf_b);
    endtask

    // Row select must be one-hot or zero, and non-zero exactly when valid
    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot_a", 32'($countones(sel_a) <= 1), 32'd1);
            chk("onehot_b", 32'($countones(sel_b) <= 1), 32'd1);
            chk("selvalid_a", 32'(sel_a != 4'd0), 32'(valid_a));
            chk("selvalid_b", 32'(sel_b != 8'd0), 32'(valid_b));
        end
    end

    initial begin
        rst_n = 1'b0;
        drv_a(1'b1, 1'b0, 1'b0, 1'b0);
        e_b = 1'b1; push_b = 1'b0; pop_b = 1'b0; clr_b = 1'b0;
        #12;
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_sel",   32'(sel_a),   32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_we",    32'(we_a),    32'd0);
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_full",  32'(full_a),  32'd0);
        chk("rst_top",   32'(top_a),   32'd0);
        chk("rst_ovf",   32'(ovf_a),   32'd0);
        chk("rst_udf",   32'(udf_a),   32'd0);
        chk("rst_count_b", 32'(count_b), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Four pushes fill the stack bottom-up
        for (int i = 0; i < 4; i++) begin
            drv_a(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            chk("push_sel",   32'(sel_a),   32'(1 << i));
            chk("push_we",    32'(we_a),    32'd1);
            chk("push_valid", 32'(valid_a), 32'd1);
            chk("push_count", 32'(count_a), 32'(i + 1));
        end
        chk("fill_full", 32'(full_a), 32'd1);
        chk("fill_top",  32'(top_a),  32'd3);

        // Push when full is rejected
        tick();
        chk("ovf_valid", 32'(valid_a), 32'd0);
        chk("ovf_flag",  32'(ovf_a),   32'd1);
        chk("ovf_count", 32'(count_a), 32'd4);
        drv_a(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ovf_clr", 32'(ovf_a), 32'd0);

        // Four pops drain top-down
        for (int i = 0; i < 4; i++) begin
            drv_a(1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            chk("pop_sel",   32'(sel_a),   32'(8 >> i));
            chk("pop_we",    32'(we_a),    32'd0);
            chk("pop_valid", 32'(valid_a), 32'd1);
            chk("pop_count", 32'(count_a), 32'(3 - i));
            if (i == 0) chk("pop_top", 32'(top_a), 32'd2);
        end
        chk("drain_empty", 32'(empty_a), 32'd1);

        // Pop when empty is rejected
        tick();
        chk("udf_flag",  32'(udf_a), 32'd1);
        chk("udf_sel",   32'(sel_a), 32'd0);
        chk("udf_count", 32'(count_a), 32'd0);
        // Rejection together with clear: flag stays set
        drv_a(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("udf_setwins", 32'(udf_a), 32'd1);
        drv_a(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("udf_clr", 32'(udf_a), 32'd0);

        // Replace top at count 2
        drv_a(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_repl_count", 32'(count_a), 32'd2);
        drv_a(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("repl_sel",   32'(sel_a),   32'd2);
        chk("repl_we",    32'(we_a),    32'd1);
        chk("repl_count", 32'(count_a), 32'd2);
        chk("repl_flags", 32'({ovf_a, udf_a}), 32'd0);

        // Drain, then push+pop on empty behaves as a push
        drv_a(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk("pre_pp_empty", 32'(empty_a), 32'd1);
        drv_a(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("pp_empty_sel",   32'(sel_a),   32'd1);
        chk("pp_empty_we",    32'(we_a),    32'd1);
        chk("pp_empty_count", 32'(count_a), 32'd1);
        chk("pp_empty_udf",   32'(udf_a),   32'd0);

        // Disabled: push held three cycles does nothing
        drv_a(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dis_valid", 32'(valid_a), 32'd0);
            chk("dis_count", 32'(count_a), 32'd1);
        end

        // Asynchronous reset in the middle of a push burst
        drv_a(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("burst_count", 32'(count_a), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count_a), 32'd0);
        chk("arst_empty", 32'(empty_a), 32'd1);
        chk("arst_sel",   32'(sel_a),   32'd0);
        chk("arst_valid", 32'(valid_a), 32'd0);
        chk("arst_top",   32'(top_a),   32'd0);
        drv_a(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(valid_a), 32'd0);
        chk("post_rst_count", 32'(count_a), 32'd0);

        // ADDR_W=3: eight pushes walk every row, ninth overflows
        for (int i = 0; i < 8; i++) begin
            push_b = 1'b1;
            tick();
            chk("b_push_sel",   32'(sel_b),   32'(1 << i));
            chk("b_push_we",    32'(we_b),    32'd1);
            chk("b_push_count", 32'(count_b), 32'(i + 1));
        end
        chk("b_full", 32'(full_b), 32'd1);
        chk("b_top",  32'(top_b),  32'd7);
        tick();
        chk("b_ovf",       32'(ovf_b),   32'd1);
        chk("b_ovf_valid", 32'(valid_b), 32'd0);
        chk("b_ovf_count", 32'(count_b), 32'd8);
        push_b = 1'b0;
        tick();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
